// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its two-requester arbiter.
package alu_pkg;

  localparam int unsigned DEFAULT_DATA_W = 32;

  typedef enum logic [1:0] {
    OP_BEQ = 2'b00,
    OP_ADD = 2'b01,
    OP_SUB = 2'b10,
    OP_ILL = 2'b11
  } alu_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    FULL = 1'b1
  } arb_state_e;

endpackage

// File: rtl/alu.sv
// Combinational ALU: add, subtract and equality compare on signed operands.
module alu
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W = DEFAULT_DATA_W
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  alu_op_e           op,
  output logic [DATA_W-1:0] result,
  output logic              eq
);

  always_comb begin
    result = '0;
    unique case (op)
      OP_ADD:  result = a + b;
      OP_SUB:  result = a - b;
      default: result = '0;
    endcase
  end

  assign eq = (a == b);

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between the EX operand path and the
// branch-compare path, with a one-entry registered response slot.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W = DEFAULT_DATA_W,
  parameter int unsigned ID_W   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              r0_valid,
  output logic              r0_ready,
  input  logic [DATA_W-1:0] r0_a,
  input  logic [DATA_W-1:0] r0_b,
  input  logic [1:0]        r0_op,
  input  logic              r1_valid,
  output logic              r1_ready,
  input  logic [DATA_W-1:0] r1_a,
  input  logic [DATA_W-1:0] r1_b,
  input  logic [1:0]        r1_op,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [ID_W-1:0]   rsp_id,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_branch,
  output logic              rsp_err
);

  arb_state_e        state, state_next;
  logic              last_grant;
  logic              grant1;
  logic              can_accept;
  logic              accept;
  logic [DATA_W-1:0] sel_a, sel_b;
  alu_op_e           sel_op;
  logic [DATA_W-1:0] alu_result;
  logic              alu_eq;
  logic [DATA_W-1:0] cap_result;
  logic              cap_branch;
  logic              cap_err;

  // Requester 1 wins when alone, or when both contend and requester 0 went last.
  assign grant1     = r1_valid & (~r0_valid | ~last_grant);
  assign can_accept = (state == IDLE) | rsp_ready;
  assign r0_ready   = ~reset & can_accept & r0_valid & ~grant1;
  assign r1_ready   = ~reset & can_accept & r1_valid & grant1;
  assign accept     = r0_ready | r1_ready;

  assign sel_a  = grant1 ? r1_a : r0_a;
  assign sel_b  = grant1 ? r1_b : r0_b;
  assign sel_op = alu_op_e'(grant1 ? r1_op : r0_op);

  alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .a      (sel_a),
    .b      (sel_b),
    .op     (sel_op),
    .result (alu_result),
    .eq     (alu_eq)
  );

  always_comb begin
    cap_result = '0;
    cap_branch = 1'b0;
    cap_err    = 1'b0;
    unique case (sel_op)
      OP_ADD,
      OP_SUB:  cap_result = alu_result;
      OP_BEQ:  cap_branch = alu_eq;
      default: cap_err    = 1'b1;
    endcase
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (accept) state_next = FULL;
      FULL:    if (!accept && rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      rsp_id     <= '0;
      rsp_result <= '0;
      rsp_branch <= 1'b0;
      rsp_err    <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        last_grant <= grant1;
        rsp_id     <= ID_W'(grant1);
        rsp_result <= cap_result;
        rsp_branch <= cap_branch;
        rsp_err    <= cap_err;
      end
    end
  end

  assign rsp_valid = (state == FULL);

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single combinational ALU between two requesters: requester 0 is the EX-stage operand path, requester 1 is the branch-compare path.
- Arbitrates round-robin, drives the ALU, and registers each result into a one-entry response slot with a valid/ready handshake.
- Sits between ID/EX operand selection and the EX/MEM register; it replaces direct wiring of the ALU.

Parameters:
- DATA_W, 32, operand and result width (signed two's complement).
- ID_W, 1, width of the requester tag returned with each response.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- r0_valid  in  1  requester 0 has an operation pending.
- r0_ready  out  1  requester 0 operation accepted this cycle.
- r0_a  in  DATA_W  requester 0 operand a (read data 1).
- r0_b  in  DATA_W  requester 0 operand b (mux output).
- r0_op  in  2  requester 0 op: 00 compare-equal, 01 add, 10 sub, 11 illegal.
- r1_valid / r1_ready / r1_a / r1_b / r1_op: same as the r0_* ports, for requester 1.
- rsp_valid  out  1  response slot holds a result.
- rsp_ready  in  1  consumer takes the response this cycle.
- rsp_id  out  ID_W  requester that issued the held result.
- rsp_result  out  DATA_W  registered ALU result.
- rsp_branch  out  1  registered equal flag (op 00 only).
- rsp_err  out  1  op was 11.

Behaviour:
- Clock/reset: one clock domain, clk. Reset is synchronous, active-high.
- Reset values: rsp_valid=0, rsp_id=0, rsp_result=0, rsp_branch=0, rsp_err=0, state=IDLE, last_grant=1 (so requester 0 wins the first contest).
- Reset mid-operation: a held response is discarded and is not replayed. r*_ready is 0 while reset is high.
- States:
  - IDLE: slot empty.
  - FULL: slot holds an unconsumed response.
- Slot availability: can_accept = (state==IDLE) | rsp_ready.
- Grant (combinational, from valids and last_grant only):
  - Only one valid: that requester.
  - Both valid: the requester != last_grant.
  - r_grant_ready = can_accept & granted requester's valid.
  - The non-granted ready is 0.
- Acceptance: rX_valid & rX_ready in cycle N.
  - The ALU computes on rX_a/rX_b/rX_op in cycle N.
  - The result is registered at the edge ending N; rsp_valid=1 in N+1 (latency 1).
  - last_grant <= X.
  - rsp_id <= X.
- Transitions:
  - IDLE → FULL on accept.
  - FULL → IDLE on rsp_ready with no accept.
  - FULL → FULL on rsp_ready with a simultaneous accept: back-to-back issue, one op per cycle sustained.
  - FULL with rsp_ready=0: hold all rsp_* outputs stable; both readies 0.
- Result rules (capture logic, independent of ALU output hold behaviour):
  - op 01: result=a+b, wrap modulo 2^DATA_W, no overflow flag; branch=0; err=0.
  - op 10: result=a-b, wrap modulo 2^DATA_W; branch=0; err=0.
  - op 00: result=0; branch=(a==b); err=0.
  - op 11: result=0; branch=0; err=1. The op is still accepted and consumes a slot.
- Requester contract: once valid is high, valid, a, b and op stay stable until ready. The arbiter never retracts a ready it has given.
- Fairness: with both requesters continuously valid and rsp_ready=1, grants alternate every cycle, so neither requester waits more than 1 accept.
- last_grant is unchanged in cycles with no accept.

Decomposition:
- Shared package alu_pkg:
  - ALU op constants: OP_BEQ=2'b00, OP_ADD=2'b01, OP_SUB=2'b10, OP_ILL=2'b11.
  - Arbiter state encoding: IDLE, FULL.
  - DATA_W default.
- Sub-module: the existing alu, instantiated once, fed by the grant mux. The capture logic in alu_arbiter applies the result rules above rather than trusting ALU output for op 00/11.

Test Plan:
1. Reset, then r0: a=5, b=7, op=01, rsp_ready=1 → r0_ready=1 same cycle; next cycle rsp_valid=1, rsp_result=12, rsp_id=0, branch=0, err=0.
2. Both valid the same cycle after reset (r0: 10−3 op 10; r1: 4==4 op 00), rsp_ready=1 → cycle 0 grants r0 (result 7, id 0); cycle 1 grants r1 (result 0, branch=1, id 1).
3. Backpressure: accept r0 op 01 (1+1), hold rsp_ready=0 for 3 cycles with r1 valid → rsp_result=2 stable, r1_ready=0 throughout; raise rsp_ready → r1 accepted that cycle, its response next cycle.
4. Wrap/sign: a=0x7FFFFFFF, b=1, op 01 → result 0x80000000; a=0, b=1, op 10 → result 0xFFFFFFFF; a=3, b=4, op 00 → branch=0, result 0.
5. Illegal op: r1 op=11 → accepted, rsp_err=1, result 0, branch 0, id 1.
6. Reset while FULL (rsp_ready=0) → next cycle rsp_valid=0, readies 0 during reset; first post-reset contest with both valid grants r0.
